control_ventilacion_alarma: RTL and testbench
=============================================

// Module: control_ventilacion_alarma
// PURPOSE
//   Thermal supervisor FSM. Consumes sampled temperature words and decides the
//   Ventilacion / Alarma flags that drive the 7-segment status indicator.
//   Also drives the fan enable. Applies hysteresis, N-sample persistence
//   filtering, a minimum fan on-time and a latched, acknowledged alarm.
//   Sits between the temperature sampler and the 7-seg activation logic.
// PARAMETERS
//   TEMP_W      5   temperature word width (unsigned, degrees C)
//   T_VENT_ON   24  fan-on threshold (temp >= T_VENT_ON)
//   T_VENT_OFF  22  fan-off threshold (temp <= T_VENT_OFF); must be < T_VENT_ON
//   T_ALARM     30  alarm threshold (temp >= T_ALARM); must be >= T_VENT_ON
//   T_ALARM_CLR 28  alarm-clear threshold (temp <= T_ALARM_CLR); must be < T_ALARM
//   PERSIST     4   consecutive qualifying valid samples required (>= 1)
//   MIN_ON      16  minimum fan on-time in tick pulses while in VENT (>= 0)
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   temp         in   TEMP_W  temperature sample; qualified by temp_valid
//   temp_valid   in   1       1-cycle strobe: temp holds a new sample
//   tick         in   1       1-cycle timebase strobe for the min-on timer
//   alarm_ack    in   1       operator acknowledge; level, sampled every cycle
//   Ventilacion  out  1       1 only in VENT
//   Alarma       out  1       1 only in ALARM
//   fan_on       out  1       fan drive; 1 in VENT and ALARM
//   estado       out  2       state code: NORMAL=00, VENT=01, ALARM=10
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=NORMAL; all counters=0; Ventilacion,
//     Alarma and fan_on=0; estado=00. Reset mid-operation aborts immediately.
//   - Moore outputs, decoded from the state register only. No combinational
//     path from any input to any output.
//   - Counters cnt_alm, cnt_up and cnt_dn are clog2(PERSIST+1) bits and
//     saturate at PERSIST. They update only on temp_valid=1.
//     - Qualifying sample: count+1. Non-qualifying sample: count cleared.
//     - temp_valid=0: count holds.
//   - Qualifying conditions: cnt_alm uses temp>=T_ALARM. cnt_up uses
//     temp>=T_VENT_ON. cnt_dn uses temp<=T_VENT_OFF in VENT and
//     temp<=T_ALARM_CLR in ALARM. Compares are unsigned, full TEMP_W width.
//   - on_timer is clog2(MIN_ON+1) bits. It is cleared on entry to VENT.
//     In VENT it counts +1 per tick and saturates at MIN_ON.
//   - All counters and on_timer clear on every state change.
//   - Transitions occur on the clock edge that registers the PERSIST-th
//     qualifying sample. The state and outputs change at that same edge.
//     - NORMAL: cnt_alm reaches PERSIST -> ALARM. Otherwise, if cnt_up
//       reaches PERSIST -> VENT. ALARM wins when both reach PERSIST together.
//     - VENT: cnt_alm reaches PERSIST -> ALARM; this overrides the min-on
//       timer. Otherwise -> NORMAL on the edge where cnt_dn==PERSIST and
//       on_timer==MIN_ON. cnt_dn stays saturated while waiting for on_timer.
//       A hotter sample before expiry clears cnt_dn.
//     - ALARM: latched. -> VENT on the edge where alarm_ack=1 and
//       cnt_dn==PERSIST; on_timer restarts. alarm_ack while not cooled is
//       ignored and is not remembered. ALARM never returns directly to NORMAL.
//   - temp_valid and tick in the same cycle: both are processed in that cycle.
//   - Unused state code 11: recovers to NORMAL on the next edge with outputs 0.
// TESTING (defaults)
//   1. Reset, then 4 valid samples of 25 -> at the 4th sample edge:
//      Ventilacion=1, fan_on=1, estado=01. After 3 samples: still NORMAL.
//   2. 3x25, 1x23, 4x25 -> VENT only after the last 4 samples.
//      The 23 sample clears cnt_up.
//   3. In VENT, 4x21 with only 10 ticks -> stays VENT. 6 more ticks ->
//      NORMAL at the 16th tick edge, with no further samples needed.
//   4. In NORMAL, 4x31 -> ALARM directly: Alarma=1, Ventilacion=0, fan_on=1.
//      alarm_ack=1 held with samples of 29 -> stays ALARM.
//      Then 4x27 with ack=1 -> VENT at the 4th edge.
//   5. In VENT with on_timer=5, 4x30 -> ALARM immediately, ignoring MIN_ON.
//   6. rst_n pulsed low mid-ALARM, asynchronously between clock edges ->
//      outputs 0 and estado=00 with no clock edge needed. Counters restart.

Source files
------------

// File: rtl/control_ventilacion_alarma_if.sv
// Signal bundle between the temperature sampler / operator panel and the
// thermal supervisor that feeds the 7-segment status indicator.
interface control_ventilacion_alarma_if #(
    parameter int TEMP_W = 5
);
    logic [TEMP_W-1:0] temp;
    logic              temp_valid;
    logic              tick;
    logic              alarm_ack;
    logic              Ventilacion;
    logic              Alarma;
    logic              fan_on;
    logic [1:0]        estado;

    modport master (
        output temp, temp_valid, tick, alarm_ack,
        input  Ventilacion, Alarma, fan_on, estado
    );

    modport slave (
        input  temp, temp_valid, tick, alarm_ack,
        output Ventilacion, Alarma, fan_on, estado
    );
endinterface

// File: rtl/control_ventilacion_alarma.sv
// Thermal supervisor: hysteresis + persistence filtered fan / alarm FSM with
// minimum fan on-time and a latched alarm that needs cooling plus acknowledge.
module control_ventilacion_alarma #(
    parameter int TEMP_W      = 5,
    parameter int T_VENT_ON   = 24,
    parameter int T_VENT_OFF  = 22,
    parameter int T_ALARM     = 30,
    parameter int T_ALARM_CLR = 28,
    parameter int PERSIST     = 4,
    parameter int MIN_ON      = 16
) (
    input logic clk,
    input logic rst_n,
    control_ventilacion_alarma_if.slave bus
);
    localparam int CW = $clog2(PERSIST + 1);
    localparam int TW = (MIN_ON > 0) ? $clog2(MIN_ON + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);
    localparam logic [TW-1:0] TMR_MAX = TW'(MIN_ON);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_VENT   = 2'b01,
        ST_ALARM  = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_alm_r, cnt_up_r, cnt_dn_r;
    logic [CW-1:0] cnt_alm_nxt_s, cnt_up_nxt_s, cnt_dn_nxt_s;
    logic [TW-1:0] on_timer_r, on_timer_nxt_s;
    logic          alm_q_s, up_q_s, dn_q_s;
    logic          ventilacion_r, alarma_r, fan_on_r;
    logic [1:0]    estado_r;

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        if (c >= CNT_MAX) begin
            return c;
        end else begin
            return c + CW'(1);
        end
    endfunction

    function automatic logic [TW-1:0] tmr_inc(input logic [TW-1:0] t);
        if (t >= TMR_MAX) begin
            return t;
        end else begin
            return t + TW'(1);
        end
    endfunction

    // Qualify the sample, advance the persistence counters and timer, pick the next state.
    always_comb begin
        alm_q_s = (bus.temp >= TEMP_W'(T_ALARM));
        up_q_s  = (bus.temp >= TEMP_W'(T_VENT_ON));
        case (state_r)
            ST_VENT:  dn_q_s = (bus.temp <= TEMP_W'(T_VENT_OFF));
            ST_ALARM: dn_q_s = (bus.temp <= TEMP_W'(T_ALARM_CLR));
            default:  dn_q_s = 1'b0;
        endcase

        if (bus.temp_valid) begin
            cnt_alm_nxt_s = alm_q_s ? cnt_inc(cnt_alm_r) : CW'(0);
            cnt_up_nxt_s  = up_q_s  ? cnt_inc(cnt_up_r)  : CW'(0);
            cnt_dn_nxt_s  = dn_q_s  ? cnt_inc(cnt_dn_r)  : CW'(0);
        end else begin
            cnt_alm_nxt_s = cnt_alm_r;
            cnt_up_nxt_s  = cnt_up_r;
            cnt_dn_nxt_s  = cnt_dn_r;
        end

        if ((state_r == ST_VENT) && bus.tick) begin
            on_timer_nxt_s = tmr_inc(on_timer_r);
        end else begin
            on_timer_nxt_s = on_timer_r;
        end

        state_nxt_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (cnt_alm_nxt_s == CNT_MAX) begin
                    state_nxt_s = ST_ALARM;
                end else if (cnt_up_nxt_s == CNT_MAX) begin
                    state_nxt_s = ST_VENT;
                end else begin
                    state_nxt_s = ST_NORMAL;
                end
            end
            ST_VENT: begin
                // Alarm escalation takes priority over the minimum on-time.
                if (cnt_alm_nxt_s == CNT_MAX) begin
                    state_nxt_s = ST_ALARM;
                end else if ((cnt_dn_nxt_s == CNT_MAX) && (on_timer_nxt_s == TMR_MAX)) begin
                    state_nxt_s = ST_NORMAL;
                end else begin
                    state_nxt_s = ST_VENT;
                end
            end
            ST_ALARM: begin
                if (bus.alarm_ack && (cnt_dn_nxt_s == CNT_MAX)) begin
                    state_nxt_s = ST_VENT;
                end else begin
                    state_nxt_s = ST_ALARM;
                end
            end
            default: state_nxt_s = ST_NORMAL;
        endcase
    end

    // State, counters and registered Moore outputs; every state change restarts all counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_NORMAL;
            cnt_alm_r     <= CW'(0);
            cnt_up_r      <= CW'(0);
            cnt_dn_r      <= CW'(0);
            on_timer_r    <= TW'(0);
            ventilacion_r <= 1'b0;
            alarma_r      <= 1'b0;
            fan_on_r      <= 1'b0;
            estado_r      <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_alm_r  <= CW'(0);
                cnt_up_r   <= CW'(0);
                cnt_dn_r   <= CW'(0);
                on_timer_r <= TW'(0);
            end else begin
                cnt_alm_r  <= cnt_alm_nxt_s;
                cnt_up_r   <= cnt_up_nxt_s;
                cnt_dn_r   <= cnt_dn_nxt_s;
                on_timer_r <= on_timer_nxt_s;
            end
            case (state_nxt_s)
                ST_VENT: begin
                    ventilacion_r <= 1'b1;
                    alarma_r      <= 1'b0;
                    fan_on_r      <= 1'b1;
                    estado_r      <= 2'b01;
                end
                ST_ALARM: begin
                    ventilacion_r <= 1'b0;
                    alarma_r      <= 1'b1;
                    fan_on_r      <= 1'b1;
                    estado_r      <= 2'b10;
                end
                default: begin
                    ventilacion_r <= 1'b0;
                    alarma_r      <= 1'b0;
                    fan_on_r      <= 1'b0;
                    estado_r      <= 2'b00;
                end
            endcase
        end
    end

    assign bus.Ventilacion = ventilacion_r;
    assign bus.Alarma      = alarma_r;
    assign bus.fan_on      = fan_on_r;
    assign bus.estado      = estado_r;
endmodule

// File: tb/tb_control_ventilacion_alarma.sv
// Bench for the thermal supervisor: directed scenarios plus a randomized run
// against a rule-level reference model of the fan/alarm behaviour.
module tb_control_ventilacion_alarma;
    localparam logic [4:0] VEC_NORMAL = 5'b00000;  // {Ventilacion, Alarma, fan_on, estado}
    localparam logic [4:0] VEC_VENT   = 5'b10101;
    localparam logic [4:0] VEC_ALARM  = 5'b01110;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    // Reference model: 0 = NORMAL, 1 = VENT, 2 = ALARM
    int m_state, m_alm, m_up, m_dn, m_timer;

    control_ventilacion_alarma_if #(.TEMP_W(5)) bus ();

    control_ventilacion_alarma dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {bus.Ventilacion, bus.Alarma, bus.fan_on, bus.estado};
    endfunction

    function automatic logic [4:0] model_vec();
        case (m_state)
            1:       return VEC_VENT;
            2:       return VEC_ALARM;
            default: return VEC_NORMAL;
        endcase
    endfunction

    function automatic int bump(input int c, input int lim);
        return (c + 1 > lim) ? lim : c + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_alm = 0; m_up = 0; m_dn = 0; m_timer = 0;
    endtask

    task automatic model_step(input int t, input bit v, input bit tk, input bit a);
        int nxt;
        bit cool;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (v) begin
                cool  = (m_state == 1) ? (t <= 22) : (m_state == 2) ? (t <= 28) : 1'b0;
                m_alm = (t >= 30) ? bump(m_alm, 4) : 0;
                m_up  = (t >= 24) ? bump(m_up, 4) : 0;
                m_dn  = cool ? bump(m_dn, 4) : 0;
            end
            if (m_state == 1 && tk) m_timer = bump(m_timer, 16);
            nxt = m_state;
            if (m_state == 0) begin
                if (m_alm == 4) nxt = 2;
                else if (m_up == 4) nxt = 1;
            end else if (m_state == 1) begin
                if (m_alm == 4) nxt = 2;
                else if (m_dn == 4 && m_timer == 16) nxt = 0;
            end else begin
                if (a && m_dn == 4) nxt = 1;
            end
            if (nxt != m_state) begin
                m_state = nxt; m_alm = 0; m_up = 0; m_dn = 0; m_timer = 0;
            end
        end
    endtask

    task automatic drive(input int t, input bit v, input bit tk, input bit a);
        @(negedge clk);
        bus.temp       = 5'(t);
        bus.temp_valid = v;
        bus.tick       = tk;
        bus.alarm_ack  = a;
        @(posedge clk);
        model_step(t, v, tk, a);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.temp = 5'd0; bus.temp_valid = 1'b0; bus.tick = 1'b0; bus.alarm_ack = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.temp = 5'd0; bus.temp_valid = 1'b0; bus.tick = 1'b0; bus.alarm_ack = 1'b0;
        model_reset();
        #12;
        total++;
        if (obs() !== VEC_NORMAL) $display("FAIL reset: got %b expected %b", obs(), VEC_NORMAL);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vent_on();
        for (int i = 0; i < 4; i++) begin
            drive(25, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs() !== ((i == 3) ? VEC_VENT : VEC_NORMAL))
                $display("FAIL vent_on[%0d]: got %b expected %b", i, obs(), (i == 3) ? VEC_VENT : VEC_NORMAL);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        int seq [8] = '{25, 25, 25, 23, 25, 25, 25, 25};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(seq[i], 1'b1, 1'b0, 1'b0);
            total++;
            if (obs() !== ((i == 7) ? VEC_VENT : VEC_NORMAL))
                $display("FAIL glitch[%0d]: got %b expected %b", i, obs(), (i == 7) ? VEC_VENT : VEC_NORMAL);
            else passed++;
        end
    endtask

    task automatic test_min_on();
        for (int i = 0; i < 4; i++) drive(21, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs() !== VEC_VENT) $display("FAIL min_on_hold: got %b expected %b", obs(), VEC_VENT);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b0, 1'b1, 1'b0);
            total++;
            if (obs() !== ((i == 5) ? VEC_NORMAL : VEC_VENT))
                $display("FAIL min_on_tick[%0d]: got %b expected %b", i, obs(), (i == 5) ? VEC_NORMAL : VEC_VENT);
            else passed++;
        end
    endtask

    task automatic test_alarm();
        for (int i = 0; i < 4; i++) begin
            drive(31, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs() !== ((i == 3) ? VEC_ALARM : VEC_NORMAL))
                $display("FAIL alarm_on[%0d]: got %b expected %b", i, obs(), (i == 3) ? VEC_ALARM : VEC_NORMAL);
            else passed++;
        end
        for (int i = 0; i < 6; i++) drive(29, 1'b1, 1'($urandom_range(1, 0)), 1'b1);
        total++;
        if (obs() !== VEC_ALARM) $display("FAIL alarm_hot_ack: got %b expected %b", obs(), VEC_ALARM);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            drive(27, 1'b1, 1'b0, 1'b1);
            total++;
            if (obs() !== ((i == 3) ? VEC_VENT : VEC_ALARM))
                $display("FAIL alarm_clear[%0d]: got %b expected %b", i, obs(), (i == 3) ? VEC_VENT : VEC_ALARM);
            else passed++;
        end
    endtask

    task automatic test_alarm_override();
        for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(30, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs() !== ((i == 3) ? VEC_ALARM : VEC_VENT))
                $display("FAIL override[%0d]: got %b expected %b", i, obs(), (i == 3) ? VEC_ALARM : VEC_VENT);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== VEC_NORMAL) $display("FAIL async_reset: got %b expected %b", obs(), VEC_NORMAL);
        else passed++;
        model_reset();
        drive(25, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(25, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs() !== ((i == 3) ? VEC_VENT : VEC_NORMAL))
                $display("FAIL restart[%0d]: got %b expected %b", i, obs(), (i == 3) ? VEC_VENT : VEC_NORMAL);
            else passed++;
        end
    endtask

    task automatic test_random();
        int t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(7, 0) == 0) ? int'($urandom_range(31, 0)) : int'($urandom_range(31, 18));
            drive(t, ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), ($urandom_range(2, 0) == 0));
            total++;
            if (obs() !== model_vec())
                $display("FAIL random[%0d] temp=%0d: got %b expected %b", i, t, obs(), model_vec());
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_vent_on();
        test_glitch();
        test_min_on();
        test_alarm();
        test_alarm_override();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
